// File: rtl/dataflow_pkg.sv
// Shared dataflow types and constants: skid occupancy encoding, legal FIFO
// read latencies and the width of the optional statistics counters.
package dataflow_pkg;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } occ_state_e;

   localparam int RD_LAT_COMB = 0;
   localparam int RD_LAT_REG  = 1;

   localparam int STATS_W = 32;

   // Number of tokens held for a given occupancy state.
   function automatic logic [1:0] occ_count(input occ_state_e s);
      return s;
   endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry circular skid buffer: 1-bit head/tail pointers plus an occupancy
// state. Writes land in entry[tail], the head entry is always presented.
module fifo_reader_skid
   import dataflow_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output occ_state_e       state_o,
   output logic [WIDTH-1:0] head_data_o
);

   logic [WIDTH-1:0] entry_q [2];
   occ_state_e       state_q, state_d;
   logic             head_q, head_d;
   logic             tail_q, tail_d;
   logic             pop_ok;

   // A pop against an empty buffer is ignored rather than corrupting pointers.
   assign pop_ok = pop_i && (state_q != S_EMPTY);

   always_comb begin
      state_d = state_q;
      head_d  = head_q ^ pop_ok;
      tail_d  = tail_q ^ push_i;
      case (state_q)
         S_EMPTY: begin
            if (push_i) state_d = S_ONE;
         end
         S_ONE: begin
            if (push_i && !pop_ok)      state_d = S_FULL;
            else if (!push_i && pop_ok) state_d = S_EMPTY;
         end
         S_FULL: begin
            if (pop_ok && !push_i) state_d = S_ONE;
         end
         default: state_d = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_EMPTY;
         head_q  <= 1'b0;
         tail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (rst) begin
               entry_q[gi] <= '0;
            end else if (push_i && (tail_q == 1'(gi))) begin
               entry_q[gi] <= push_data_i;
            end
         end
      end
   endgenerate

   assign state_o     = state_q;
   assign head_data_o = entry_q[head_q];

   // The credit rule upstream must never push into a full buffer without a pop.
   a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
      !(push_i && !pop_ok && (state_q == S_FULL)));

endmodule

// File: rtl/fifo_reader.sv
// Read-port controller for a single-clock FIFO feeding a valid/ready stream.
// Optional statistics outputs are enabled by defining FIFO_READER_STATS_EN.
module fifo_reader
   import dataflow_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int READ_LATENCY = RD_LAT_REG
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               fifo_empty,
   output logic               fifo_read,
   input  logic [WIDTH-1:0]   fifo_dout,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready
`ifdef FIFO_READER_STATS_EN
   ,
   output logic [STATS_W-1:0] tok_count,
   output logic [STATS_W-1:0] stall_count
`endif
);

   occ_state_e       state;
   logic [WIDTH-1:0] head_data;
   logic             pop;
   logic             push;
   logic             inflight;
   logic [2:0]       credit_used;
   logic [2:0]       credit_limit;

   assign out_valid = (state != S_EMPTY);
   assign out_data  = head_data;
   assign pop       = out_valid && out_ready;

   // occupancy + inflight - pop < 2, rearranged to stay unsigned.
   assign credit_used  = {1'b0, occ_count(state)} + {2'b00, inflight};
   assign credit_limit = 3'd2 + {2'b00, pop};
   assign fifo_read    = !rst && !fifo_empty && (credit_used < credit_limit);

   generate
      if (READ_LATENCY == RD_LAT_REG) begin : g_lat_reg
         logic inflight_q;
         always_ff @(posedge clk) begin
            if (rst) inflight_q <= 1'b0;
            else     inflight_q <= fifo_read;
         end
         assign inflight = inflight_q;
         assign push     = inflight_q;
      end else begin : g_lat_comb
         assign inflight = 1'b0;
         assign push     = fifo_read;
      end
   endgenerate

   fifo_reader_skid #(
      .WIDTH(WIDTH)
   ) u_skid (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i (fifo_dout),
      .pop_i       (pop),
      .state_o     (state),
      .head_data_o (head_data)
   );

`ifdef FIFO_READER_STATS_EN
   logic [STATS_W-1:0] tok_count_q;
   logic [STATS_W-1:0] stall_count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         tok_count_q   <= '0;
         stall_count_q <= '0;
      end else begin
         if (pop)                    tok_count_q   <= tok_count_q + STATS_W'(1);
         if (out_valid && !out_ready) stall_count_q <= stall_count_q + STATS_W'(1);
      end
   end

   assign tok_count   = tok_count_q;
   assign stall_count = stall_count_q;
`endif

endmodule

// File: doc/fifo_reader.md
Name: fifo_reader

Overview:
- Consumer-side controller for the read port of the team's single-clock FIFO.
  - Watches empty.
  - Issues read pulses.
  - Captures dout after the FIFO's read latency.
- Re-presents tokens downstream on a valid/ready stream.
- Holds a 2-entry skid buffer, so an actor input sustains 1 token/cycle despite registered RAM reads.
- Sits between each FIFO instance and the input port of the consuming dataflow actor.

Parameters:
- WIDTH, 8, token width in bits; must match the FIFO WIDTH.
- READ_LATENCY, 1, cycles from fifo_read asserted to valid fifo_dout; legal values 0 or 1.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- fifo_empty  input  1  FIFO empty flag
- fifo_read  output  1  read strobe to FIFO; one token is consumed per high cycle
- fifo_dout  input  WIDTH  FIFO read data
- out_data  output  WIDTH  head token to actor
- out_valid  output  1  out_data holds a token
- out_ready  input  1  actor accepts token this cycle

Behaviour:
- Reset: rst is synchronous, active-high; clk is the clock.
  - In any rst cycle: fifo_read=0, so no FIFO pointer moves.
  - After the rst edge: out_valid=0, out_data=0, occupancy=0, in-flight=0, buffer entries=0, head/tail pointers=0.
- Storage:
  - 2-entry circular buffer with 1-bit head and tail pointers.
  - Occupancy state enum: S_EMPTY(0), S_ONE(1), S_FULL(2).
- pop = out_valid && out_ready.
- out_valid = (state != S_EMPTY). out_data = entry[head]. Both are registered-state driven, with no combinational path from out_ready to out_valid.
- Read issue (combinational): fifo_read = !rst && !fifo_empty && (occupancy + inflight - pop < 2).
  - inflight applies only for READ_LATENCY=1.
  - This is the only out_ready -> fifo_read path.
- READ_LATENCY=1:
  - inflight register <= fifo_read.
  - The cycle after a read, fifo_dout is written to entry[tail] and tail toggles (push = inflight).
- READ_LATENCY=0:
  - push = fifo_read; fifo_dout is written the same edge.
- Occupancy transitions (push, pop):
  - S_EMPTY: push -> S_ONE.
  - S_ONE: push&!pop -> S_FULL; !push&pop -> S_EMPTY; push&pop -> S_ONE.
  - S_FULL: pop&!push -> S_ONE; push&pop -> S_FULL.
  - Push while S_FULL without pop is impossible by the credit rule; assert this.
- Latency:
  - FIFO non-empty, reader idle: out_valid rises READ_LATENCY+1 edges after fifo_empty falls.
  - With READ_LATENCY=1 that is 2 cycles: read at cycle N, capture at N+1, valid visible from N+1 after the edge.
- Throughput:
  - With out_ready held high and the FIFO never empty, fifo_read and pop are both high every cycle in steady state.
- Backpressure:
  - With out_ready low, at most 2 tokens are drained from the FIFO.
  - The in-flight token is always guaranteed a slot.
- fifo_empty rising while a read is in flight: the in-flight token is still captured; no further reads are issued.
- Token order is strictly preserved. No token is dropped or duplicated.
- Reset mid-operation:
  - Buffered and in-flight tokens are discarded.
  - The system resets the FIFO with the same rst.

Optional Feature:
- FIFO_READER_STATS_EN defined:
  - Adds output tok_count[31:0]: reset 0, +1 on every pop, wraps at 2^32.
  - Adds output stall_count[31:0]: +1 each cycle out_valid && !out_ready, wraps.
- Undefined: neither port exists and no counter logic is generated.

Decomposition:
- Shared package dataflow_pkg:
  - occupancy state typedef (S_EMPTY/S_ONE/S_FULL, 2 bits).
  - constants for legal READ_LATENCY values.
  - stats counter width (32).
- Natural sub-module: fifo_reader_skid.
  - Contents: 2-entry buffer, pointers, state.
  - Ports: push, push_data, pop, occupancy, head data.
  - fifo_reader keeps read-issue, in-flight tracking and stats.

Test Plan:
1. Reset with FIFO holding 3 tokens (0x11,0x22,0x33), rst held 4 cycles -> fifo_read=0 throughout; out_valid=0, out_data=0 after the rst edge.
2. FIFO preloaded with 0x01..0x08, out_ready=1, READ_LATENCY=1 -> out_valid from cycle 2; tokens 0x01..0x08 in order on 8 consecutive cycles; fifo_read high 8 consecutive cycles.
3. FIFO holds 5 tokens, out_ready=0 for 10 cycles -> exactly 2 fifo_read pulses; state S_FULL; out_data=first token; then out_ready=1 -> remaining 3 tokens follow back-to-back with no gap.
4. Alternating out_ready (1,0,1,0...) with 6 tokens -> no loss or duplication; order preserved; the no-push-when-full assertion never fires.
5. Single token 0xA5 written into an empty FIFO, then empty again -> one fifo_read; out_valid for exactly one token 0xA5; no read while fifo_empty=1.
6. rst asserted while state=S_ONE and inflight=1 -> next cycle out_valid=0; in-flight token not captured; with FIFO_READER_STATS_EN, tok_count and stall_count=0.
